// File: rtl/spike_threshold_timer_pkg.sv
// Shared definitions for the sort-consumer stages: widths, the default window
// length and the spike-timer state enumeration.
package sort_pkg;

  localparam int WINDOW_DEFAULT = 16;
  localparam int THERM_W        = 16;
  localparam int CNT_W          = 5;
  localparam int TIME_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spike_threshold_timer_therm2bin.sv
// Combinational decode of a sorted 16-bit thermometer into a 5-bit count plus a
// flag for vectors that are not a clean run of ones from bit 15 downward.
module therm2bin
  import sort_pkg::*;
(
  input  logic [THERM_W-1:0] therm,
  output logic [CNT_W-1:0]   count,
  output logic               malformed
);

  // A clean thermometer's popcount equals its run length from the top, and a
  // malformed vector is reported by popcount, so one adder tree covers both.
  always_comb begin
    count = '0;
    for (int i = 0; i < THERM_W; i++) begin
      count = count + CNT_W'(therm[i]);
    end
  end

  // Malformed exactly when some set bit sits directly below a clear bit.
  assign malformed = |(therm[THERM_W-2:0] & ~therm[THERM_W-1:1]);

endmodule

// File: rtl/spike_threshold_timer.sv
// Gamma-window spike timer: counts decoded spikes each cycle of a window and
// reports the first cycle at which the latched threshold is met.
module spike_threshold_timer
  import sort_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gamma_start,
  input  logic [CNT_W-1:0]   threshold,
  input  logic [THERM_W-1:0] therm_in,
  output logic               spike_out,
  output logic [TIME_W-1:0]  spike_time,
  output logic [CNT_W-1:0]   peak_count,
  output logic               done,
  output logic               busy,
  output logic               therm_err,
  output state_t             state_dbg
);

  localparam logic [TIME_W-1:0] LAST_T = TIME_W'(WINDOW - 1);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   t_q;
  logic [CNT_W-1:0]    thr_q;
  logic [CNT_W-1:0]    count;
  logic                malformed;
  logic                sampling;
  logic                hit;
  logic                last;

  therm2bin u_therm2bin (
    .therm     (therm_in),
    .count     (count),
    .malformed (malformed)
  );

  assign state_dbg = state_q;

  // Next state. gamma_start overrides everything, including a crossing or the
  // final sample of the window being aborted.
  always_comb begin
    sampling = (state_q == ST_ARMED) || (state_q == ST_FIRED);
    hit      = (state_q == ST_ARMED) && (thr_q != '0) && (count >= thr_q);
    last     = sampling && (t_q == LAST_T);
    state_d  = state_q;
    if (gamma_start) begin
      state_d = ST_ARMED;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ARMED: begin
          if (last)     state_d = ST_DONE;
          else if (hit) state_d = ST_FIRED;
        end
        ST_FIRED: begin
          if (last) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      thr_q      <= '0;
      spike_out  <= 1'b0;
      spike_time <= '0;
      peak_count <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      therm_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      spike_out <= 1'b0;
      done      <= 1'b0;
      busy      <= (state_d == ST_ARMED) || (state_d == ST_FIRED);
      if (gamma_start) begin
        t_q        <= '0;
        thr_q      <= threshold;
        peak_count <= '0;
        therm_err  <= 1'b0;
        spike_time <= '0;
      end else if (sampling) begin
        t_q <= last ? '0 : t_q + 1'b1;
        if (count > peak_count) peak_count <= count;
        if (malformed)          therm_err  <= 1'b1;
        if (hit) begin
          spike_out  <= 1'b1;
          spike_time <= t_q;
        end
        if (last) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spike_threshold_timer.sv
// Randomized and directed bench for spike_threshold_timer; a reference model
// computes each complete window's outcome, a monitor checks it at done.
module tb_spike_threshold_timer;
  import sort_pkg::*;

  localparam int W     = 16;
  localparam int EXP_W = 11;  // {fired, spike_time[3:0], peak[4:0], err}

  logic              clk = 1'b0;
  logic              reset;
  logic              gamma_start;
  logic [4:0]        threshold;
  logic [15:0]       therm_in;
  logic              spike_out;
  logic [3:0]        spike_time;
  logic [4:0]        peak_count;
  logic              done;
  logic              busy;
  logic              therm_err;
  state_t            state_dbg;

  logic [EXP_W-1:0]  exp_q[$];
  logic [15:0]       cur_v[W];
  logic              mon_fired = 1'b0;
  int                total = 0;
  int                bad   = 0;

  spike_threshold_timer #(.WINDOW(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .gamma_start (gamma_start),
    .threshold   (threshold),
    .therm_in    (therm_in),
    .spike_out   (spike_out),
    .spike_time  (spike_time),
    .peak_count  (peak_count),
    .done        (done),
    .busy        (busy),
    .therm_err   (therm_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode as the rule is stated: run of ones from bit 15, or popcount when a
  // one appears below a zero.
  function automatic int decode(input logic [15:0] v, output bit mal);
    int run = 0;
    bit gap = 0;
    mal = 0;
    for (int b = 15; b >= 0; b--) begin
      if (v[b]) begin
        if (gap) mal = 1;
        else     run++;
      end else begin
        gap = 1;
      end
    end
    return mal ? $countones(v) : run;
  endfunction

  function automatic logic [EXP_W-1:0] model(input int thr);
    bit   fired = 0;
    int   stime = 0;
    int   peak  = 0;
    bit   err   = 0;
    bit   mal;
    int   c;
    for (int t = 0; t < W; t++) begin
      c = decode(cur_v[t], mal);
      if (mal) err = 1;
      if (c > peak) peak = c;
      if (!fired && thr != 0 && c >= thr) begin
        fired = 1;
        stime = t;
      end
    end
    return {fired, 4'(stime), 5'(peak), err};
  endfunction

  function automatic logic [15:0] rand_therm();
    logic [15:0] ones = 16'hFFFF;
    int k;
    if ($urandom_range(0, 5) == 0) return 16'($urandom);
    k = $urandom_range(0, 16);
    return ~(ones >> k);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (reset) begin
      mon_fired = 1'b0;
    end else begin
      if (spike_out) begin
        check("single_spike", 32'(mon_fired), 32'd0);
        mon_fired = 1'b1;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("window_result", 32'({mon_fired, spike_time, peak_count, therm_err}), 32'(e));
          check("busy_at_done", 32'(busy), 32'd0);
        end
        mon_fired = 1'b0;
      end
      if (gamma_start) mon_fired = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [4:0] thr, input logic [15:0] tv, input bit chk_restart);
    gamma_start = 1'b1;
    threshold   = thr;
    therm_in    = tv;
    step();
    gamma_start = 1'b0;
    threshold   = 5'($urandom_range(0, 16));
    if (chk_restart) begin
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_state", 32'(state_dbg), 32'(ST_ARMED));
      check("restart_no_spike", 32'(spike_out), 32'd0);
      check("restart_no_done", 32'(done), 32'd0);
    end
  endtask

  task automatic drive_samples(input int n);
    for (int i = 0; i < n; i++) begin
      therm_in = cur_v[i];
      step();
    end
  endtask

  task automatic full_window(input logic [4:0] thr);
    exp_q.push_back(model(int'(thr)));
    pulse_start(thr, 16'($urandom), 1'b0);
    drive_samples(W);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      therm_in = 16'($urandom);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit no_gap;
    bit abort;
    logic [4:0] thr;

    // Reset held together with gamma_start: reset must win.
    reset       = 1'b1;
    gamma_start = 1'b1;
    threshold   = 5'd3;
    therm_in    = 16'hFFFF;
    step();
    step();
    reset       = 1'b0;
    gamma_start = 1'b0;
    check("rst_spike_out", 32'(spike_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_therm_err", 32'(therm_err), 32'd0);
    check("rst_spike_time", 32'(spike_time), 32'd0);
    check("rst_peak", 32'(peak_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    idle(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Step to 0xE000 at t5 with threshold 3.
    for (int t = 0; t < W; t++) cur_v[t] = (t < 5) ? 16'h0000 : 16'hE000;
    full_window(5'd3);
    check("done_pulse", 32'(done), 32'd1);
    idle(2);
    check("held_spike_time", 32'(spike_time), 32'd5);
    check("held_peak", 32'(peak_count), 32'd3);

    // Threshold 0 never fires.
    for (int t = 0; t < W; t++) cur_v[t] = 16'hFFFF;
    full_window(5'd0);
    idle(1);

    // Malformed vector then a valid crossing.
    for (int t = 0; t < W; t++) cur_v[t] = 16'h0000;
    cur_v[2] = 16'h4000;
    cur_v[4] = 16'hC000;
    full_window(5'd2);

    // Crossing on the very last sample, back-to-back with the previous window.
    for (int t = 0; t < W; t++) cur_v[t] = 16'h0000;
    cur_v[15] = 16'h8000;
    full_window(5'd1);
    check("last_spike", 32'(spike_out), 32'd1);
    check("last_done", 32'(done), 32'd1);
    idle(2);

    // Restart coincident with a crossing at t7.
    for (int t = 0; t < W; t++) cur_v[t] = 16'h0000;
    pulse_start(5'd4, 16'h0000, 1'b0);
    drive_samples(7);
    for (int t = 0; t < W; t++) cur_v[t] = rand_therm();
    exp_q.push_back(model(5));
    pulse_start(5'd5, 16'hF000, 1'b1);
    drive_samples(W);
    idle(1);

    // Reset in the middle of a fired window.
    for (int t = 0; t < W; t++) cur_v[t] = 16'h8000;
    pulse_start(5'd1, 16'h0000, 1'b0);
    drive_samples(9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_spike_out", 32'(spike_out), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_peak", 32'(peak_count), 32'd0);
    check("midrst_spike_time", 32'(spike_time), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    idle(2);
    for (int t = 0; t < W; t++) cur_v[t] = (t < 3) ? 16'h0000 : 16'hFF00;
    full_window(5'd8);

    // Randomized windows with occasional silent aborts.
    no_gap = 0;
    for (int n = 0; n < 40; n++) begin
      if (!no_gap) idle($urandom_range(0, 3));
      thr = 5'($urandom_range(0, 16));
      for (int t = 0; t < W; t++) cur_v[t] = rand_therm();
      abort = (n != 39) && ($urandom_range(0, 6) == 0);
      if (abort) begin
        pulse_start(thr, 16'($urandom), 1'b0);
        drive_samples($urandom_range(1, 15));
      end else begin
        full_window(thr);
      end
      no_gap = abort;
    end

    // Drain, bounded.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("drain", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
